// File: rtl/divider_seq.sv
// Sequential restoring divider: 2W-bit dividend / W-bit divisor, one quotient bit per clock.
// Optional macro DIVIDER_DZ_FAST_EN: a zero divisor skips the RUN steps (latency 1).
module divider_seq #(
   parameter int unsigned W = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [2*W-1:0] x,
   input  logic [W-1:0]   d,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*W-1:0] q,
   output logic [W-1:0]   r,
   output logic           dz
);

   localparam int unsigned Steps = 2 * W;
   localparam int unsigned CntW  = $clog2(Steps);
   localparam logic [CntW-1:0] LastStep = CntW'(Steps - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e         state_q, state_d;
   // x_q shifts dividend bits out of the top while quotient bits enter at the bottom.
   logic [2*W-1:0] x_q, x_d;
   logic [W-1:0]   d_q, d_d;
   logic [W-1:0]   pr_q, pr_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2*W-1:0] q_q, q_d;
   logic [W-1:0]   r_q, r_d;
   logic           dz_q, dz_d;

   logic [W:0]     pr_shift;
   logic           take;
   logic [W-1:0]   pr_next;
   logic [2*W-1:0] quo_next;
   logic           dz_skip;

   // The remainder stays below d, so it fits W bits; only the shifted value needs W+1.
   assign pr_shift = {pr_q, x_q[2*W-1]};
   assign take     = (pr_shift >= {1'b0, d_q});
   assign pr_next  = take ? (pr_shift[W-1:0] - d_q) : pr_shift[W-1:0];
   assign quo_next = {x_q[2*W-2:0], take};

`ifdef DIVIDER_DZ_FAST_EN
   assign dz_skip = (d_q == '0);
`else
   assign dz_skip = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      d_d     = d_q;
      pr_d    = pr_q;
      cnt_d   = cnt_q;
      q_d     = q_q;
      r_d     = r_q;
      dz_d    = dz_q;
      case (state_q)
         StIdle: begin
            if (in_valid) begin
               x_d     = x;
               d_d     = d;
               pr_d    = '0;
               cnt_d   = '0;
               state_d = StRun;
            end
         end
         StRun: begin
            if (dz_skip) begin
               q_d     = '1;
               r_d     = '0;
               dz_d    = 1'b1;
               state_d = StDone;
            end else begin
               x_d   = quo_next;
               pr_d  = pr_next;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LastStep) begin
                  state_d = StDone;
                  if (d_q == '0) begin
                     q_d  = '1;
                     r_d  = '0;
                     dz_d = 1'b1;
                  end else begin
                     q_d  = quo_next;
                     r_d  = pr_next;
                     dz_d = 1'b0;
                  end
               end
            end
         end
         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         x_q     <= '0;
         d_q     <= '0;
         pr_q    <= '0;
         cnt_q   <= '0;
         q_q     <= '0;
         r_q     <= '0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         d_q     <= d_d;
         pr_q    <= pr_d;
         cnt_q   <= cnt_d;
         q_q     <= q_d;
         r_q     <= r_d;
         dz_q    <= dz_d;
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign q         = q_q;
   assign r         = r_q;
   assign dz        = dz_q;

endmodule

// File: tb/tb_divider_seq.sv
// Directed and randomised self-checking bench for divider_seq (W=4).
module tb_divider_seq;

   localparam int unsigned W = 4;
`ifdef DIVIDER_DZ_FAST_EN
   localparam int DzLat = 1;
`else
   localparam int DzLat = 8;
`endif

   logic           clk = 1'b0;
   logic           rst_n;
   logic           in_valid;
   logic           in_ready;
   logic [2*W-1:0] x;
   logic [W-1:0]   d;
   logic           out_valid;
   logic           out_ready;
   logic [2*W-1:0] q;
   logic [W-1:0]   r;
   logic           dz;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   divider_seq #(.W(W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .x        (x),
      .d        (d),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .q        (q),
      .r        (r),
      .dz       (dz)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Accept one operand pair, measure latency, check result, optionally stall and inject noise.
   task automatic run_op(input string tag, input logic [7:0] xv, input logic [3:0] dv,
                         input int exp_lat, input logic [7:0] eq, input logic [3:0] er,
                         input logic edz, input int hold, input bit noise);
      int lat;
      bit seen;
      @(negedge clk);
      x        = xv;
      d        = dv;
      in_valid = 1'b1;
      check({tag, " in_ready before accept"}, in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = noise;
      x        = 8'hA5;
      d        = 4'h3;
      lat      = 0;
      seen     = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(posedge clk);
         #1;
         lat++;
         if (out_valid) seen = 1'b1;
         else if (noise) check({tag, " in_ready low in RUN"}, in_ready, 0);
      end
      check({tag, " latency"}, lat, exp_lat);
      check({tag, " q"}, q, eq);
      check({tag, " r"}, r, er);
      check({tag, " dz"}, dz, edz);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         check({tag, " held out_valid"}, out_valid, 1);
         check({tag, " held in_ready"}, in_ready, 0);
         check({tag, " held q"}, q, eq);
         check({tag, " held r"}, r, er);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({tag, " out_valid after handshake"}, out_valid, 0);
      check({tag, " in_ready after handshake"}, in_ready, 1);
   endtask

   initial begin
      bit          seen_ov;
      logic [7:0]  rx;
      logic [3:0]  rd;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      x         = '0;
      d         = '0;
      #2;
      check("reset in_ready", in_ready, 1);
      check("reset out_valid", out_valid, 0);
      check("reset q", q, 0);
      check("reset r", r, 0);
      check("reset dz", dz, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      run_op("basic 200/13", 8'd200, 4'd13, 8, 8'd15, 4'd5, 1'b0, 0, 1'b0);
      run_op("max 255/1", 8'd255, 4'd1, 8, 8'd255, 4'd0, 1'b0, 0, 1'b0);
      run_op("small 7/9", 8'd7, 4'd9, 8, 8'd0, 4'd7, 1'b0, 0, 1'b0);
      run_op("dz 100/0", 8'd100, 4'd0, DzLat, 8'd255, 4'd0, 1'b1, 0, 1'b0);
      run_op("after dz 200/13", 8'd200, 4'd13, 8, 8'd15, 4'd5, 1'b0, 0, 1'b0);
      run_op("backpressure 144/12", 8'd144, 4'd12, 8, 8'd12, 4'd0, 1'b0, 5, 1'b1);

      // Abort mid-RUN: result from the previous op (q=12) must be cleared and never reported.
      @(negedge clk);
      x        = 8'd99;
      d        = 4'd7;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("abort in_ready", in_ready, 1);
      check("abort out_valid", out_valid, 0);
      check("abort q", q, 0);
      check("abort r", r, 0);
      @(negedge clk);
      rst_n   = 1'b1;
      seen_ov = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         if (out_valid) seen_ov = 1'b1;
      end
      check("abort no out_valid", seen_ov, 0);
      run_op("rerun 99/7", 8'd99, 4'd7, 8, 8'd14, 4'd1, 1'b0, 0, 1'b0);

      for (int n = 0; n < 1000; n++) begin
         rx = 8'($urandom_range(0, 255));
         rd = 4'($urandom_range(1, 15));
         run_op("random", rx, rd, 8, rx / 8'(rd), 4'(rx % 8'(rd)), 1'b0, 0, 1'b0);
         check("random q*d+r", 32'(q) * 32'(rd) + 32'(r), 32'(rx));
         check("random r<d", (r < rd), 1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
